// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen host interface adapters: response status,
// host-interface FSM state and byte-strobe expansion.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_OKAY        = 2'b00,
      RGGEN_EXOKAY      = 2'b01,
      RGGEN_SLAVE_ERROR = 2'b10,
      RGGEN_EXIT_ERROR  = 2'b11
   } rggen_status;

   localparam rggen_status RGGEN_DECODE_ERROR = RGGEN_EXIT_ERROR;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      BUSY     = 2'b01,
      RESPONSE = 2'b10
   } rggen_host_if_state;

   // One byte lane of the write mask; callers loop over the strobe vector.
   function automatic logic [7:0] rggen_expand_strobe(input logic strobe);
      return {8{strobe}};
   endfunction

endpackage

// File: rtl/rggen_host_if_response_mux.sv
// Select-driven AND-OR collection of ready, status and read data from the
// register array; shared by all host interface adapters.
module rggen_host_if_response_mux #(
   parameter int BUS_WIDTH = 32,
   parameter int REGISTERS = 1
) (
   input  logic [REGISTERS-1:0]           i_register_select,
   input  logic [REGISTERS-1:0]           i_register_ready,
   input  logic [2*REGISTERS-1:0]         i_register_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data,
   output logic                           o_hit,
   output logic                           o_done,
   output logic [1:0]                     o_status,
   output logic [BUS_WIDTH-1:0]           o_read_data
);

   assign o_hit  = |i_register_select;
   assign o_done = |(i_register_select & i_register_ready);

   always_comb begin
      o_status    = '0;
      o_read_data = '0;
      for (int i = 0; i < REGISTERS; i++) begin
         o_status    = o_status | ({2{i_register_select[i]}} & i_register_status[2*i+:2]);
         o_read_data = o_read_data |
                       ({BUS_WIDTH{i_register_select[i]}} & i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH]);
      end
   end

endmodule

// File: rtl/rggen_host_if_apb.sv
// APB3/APB4 slave driving the rggen register command bus.
// Optional response timeout enabled by defining RGGEN_HOST_IF_TIMEOUT_EN.
module rggen_host_if_apb
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int BUS_WIDTH      = 32,
   parameter int REGISTERS      = 1,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_psel,
   input  logic                           i_penable,
   input  logic                           i_pwrite,
   input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
   input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
   input  logic [BUS_WIDTH-1:0]           i_pwdata,
   output logic                           o_pready,
   output logic [BUS_WIDTH-1:0]           o_prdata,
   output logic                           o_pslverr,
   output logic                           o_command_valid,
   output logic                           o_write,
   output logic                           o_read,
   output logic [ADDRESS_WIDTH-1:0]       o_address,
   output logic [BUS_WIDTH-1:0]           o_write_data,
   output logic [BUS_WIDTH-1:0]           o_write_mask,
   input  logic [REGISTERS-1:0]           i_register_select,
   input  logic [REGISTERS-1:0]           i_register_ready,
   input  logic [2*REGISTERS-1:0]         i_register_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

   rggen_host_if_state   state;
   logic                 hit;
   logic                 done;
   logic                 timeout;
   logic [1:0]           sel_status;
   logic [BUS_WIDTH-1:0] sel_read_data;
   logic                 complete;
   rggen_status          resp_status;
   logic [BUS_WIDTH-1:0] resp_data;
   logic [BUS_WIDTH-1:0] write_mask_next;

   rggen_host_if_response_mux #(
      .BUS_WIDTH (BUS_WIDTH),
      .REGISTERS (REGISTERS)
   ) u_response_mux (
      .i_register_select    (i_register_select),
      .i_register_ready     (i_register_ready),
      .i_register_status    (i_register_status),
      .i_register_read_data (i_register_read_data),
      .o_hit                (hit),
      .o_done               (done),
      .o_status             (sel_status),
      .o_read_data          (sel_read_data)
   );

`ifdef RGGEN_HOST_IF_TIMEOUT_EN
   localparam int COUNT_W = $clog2(TIMEOUT_CYCLES);
   logic [COUNT_W-1:0] timeout_count;

   // Held at zero outside BUSY so every command starts counting from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_count <= '0;
      end else if (state == BUSY) begin
         timeout_count <= timeout_count + 1'b1;
      end else begin
         timeout_count <= '0;
      end
   end

   assign timeout = (timeout_count == COUNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      write_mask_next = '0;
      for (int i = 0; i < BUS_WIDTH / 8; i++) begin
         write_mask_next[8*i+:8] = rggen_expand_strobe(i_pstrb[i]);
      end
   end

   // Priority: decode miss, then register done, then timeout.
   always_comb begin
      complete    = 1'b0;
      resp_status = RGGEN_OKAY;
      resp_data   = '0;
      if (state == BUSY) begin
         if (!hit) begin
            complete    = 1'b1;
            resp_status = RGGEN_DECODE_ERROR;
         end else if (done) begin
            complete    = 1'b1;
            resp_status = rggen_status'(sel_status);
            resp_data   = sel_read_data;
         end else if (timeout) begin
            complete    = 1'b1;
            resp_status = RGGEN_SLAVE_ERROR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         o_pready        <= 1'b0;
         o_prdata        <= '0;
         o_pslverr       <= 1'b0;
         o_command_valid <= 1'b0;
         o_write         <= 1'b0;
         o_read          <= 1'b0;
         o_address       <= '0;
         o_write_data    <= '0;
         o_write_mask    <= '0;
      end else begin
         case (state)
            IDLE: begin
               o_pready  <= 1'b0;
               o_prdata  <= '0;
               o_pslverr <= 1'b0;
               if (i_psel && !i_penable) begin
                  state           <= BUSY;
                  o_command_valid <= 1'b1;
                  o_write         <= i_pwrite;
                  o_read          <= !i_pwrite;
                  o_address       <= i_paddr;
                  o_write_data    <= i_pwdata;
                  o_write_mask    <= i_pwrite ? write_mask_next : '1;
               end
            end
            BUSY: begin
               if (complete) begin
                  state           <= RESPONSE;
                  o_command_valid <= 1'b0;
                  o_write         <= 1'b0;
                  o_read          <= 1'b0;
                  o_pready        <= 1'b1;
                  o_pslverr       <= resp_status[1];
                  o_prdata        <= (o_read && !resp_status[1]) ? resp_data : '0;
               end
            end
            RESPONSE: begin
               state     <= IDLE;
               o_pready  <= 1'b0;
               o_prdata  <= '0;
               o_pslverr <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_host_if_apb.sv
// Randomised and directed bench for rggen_host_if_apb against a
// transaction-level model of APB-to-register-command behaviour.
module tb_rggen_host_if_apb;

   localparam int AW = 16;
   localparam int BW = 32;
   localparam int NR = 2;
   localparam int TO = 8;
`ifdef RGGEN_HOST_IF_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [3:0]    pstrb;
   logic [BW-1:0] pwdata;
   logic          o_pready, o_pslverr, o_command_valid, o_write, o_read;
   logic [BW-1:0] o_prdata, o_write_data, o_write_mask;
   logic [AW-1:0] o_address;
   logic [NR-1:0] reg_sel, reg_ready;
   logic [2*NR-1:0]  reg_status;
   logic [BW*NR-1:0] reg_rdata;

   rggen_host_if_apb #(
      .ADDRESS_WIDTH  (AW),
      .BUS_WIDTH      (BW),
      .REGISTERS      (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .i_psel               (psel),
      .i_penable            (penable),
      .i_pwrite             (pwrite),
      .i_paddr              (paddr),
      .i_pstrb              (pstrb),
      .i_pwdata             (pwdata),
      .o_pready             (o_pready),
      .o_prdata             (o_prdata),
      .o_pslverr            (o_pslverr),
      .o_command_valid      (o_command_valid),
      .o_write              (o_write),
      .o_read               (o_read),
      .o_address            (o_address),
      .o_write_data         (o_write_data),
      .o_write_mask         (o_write_mask),
      .i_register_select    (reg_sel),
      .i_register_ready     (reg_ready),
      .i_register_status    (reg_status),
      .i_register_read_data (reg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle, set by the driver from the model.
   logic          chk_en = 1'b0;
   logic          e_valid = 1'b0, e_pready = 1'b0, e_write = 1'b0, e_pslverr = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [BW-1:0] e_wdata = '0, e_mask = '0, e_prdata = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("command_valid", 64'(o_command_valid), 64'(e_valid));
         chk("pready", 64'(o_pready), 64'(e_pready));
         if (e_valid) begin
            chk("write", 64'(o_write), 64'(e_write));
            chk("read", 64'(o_read), 64'(!e_write));
            chk("address", 64'(o_address), 64'(e_addr));
            chk("write_data", 64'(o_write_data), 64'(e_wdata));
            chk("write_mask", 64'(o_write_mask), 64'(e_mask));
         end
         if (e_pready) begin
            chk("pslverr", 64'(o_pslverr), 64'(e_pslverr));
            chk("prdata", 64'(o_prdata), 64'(e_prdata));
         end
      end
   end

   function automatic logic [BW-1:0] model_mask(input logic [3:0] s);
      logic [BW-1:0] m = '0;
      for (int b = 0; b < BW; b++) m[b] = s[b/8];
      return m;
   endfunction

   // Values observed by the driver for literal checks on directed transfers.
   int            last_lat, last_vcnt;
   logic [BW-1:0] last_prdata, last_mask;
   logic          last_pslverr;

   // One APB transfer; d = BUSY cycle (1-based) on which the selected register
   // raises ready, 0 = never. Starts and ends just after a rising edge.
   task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] data,
                          input logic [3:0] strb, input logic [1:0] sel, input int d,
                          input logic [1:0] st, input logic [BW-1:0] rd, input bit drop);
      int k;
      logic [1:0] est;
      int idx;
      idx = (sel == 2'b10) ? 1 : 0;
      if (sel == 2'b00) begin
         k = 1; est = 2'b11;
      end else if (TO_EN && (d == 0 || d > TO)) begin
         k = TO; est = 2'b10;
      end else begin
         k = d; est = st;
      end
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      reg_sel = '0; reg_ready = '0;
      e_valid = 1'b0; e_pready = 1'b0; chk_en = 1'b1;
      last_lat = 0; last_vcnt = 0;
      for (int c = 1; c <= k + 1; c++) begin
         @(posedge clk); #1;
         penable = 1'b1;
         if (drop) begin psel = 1'b0; penable = 1'b0; end
         reg_sel    = sel;
         reg_ready  = (NR'($urandom) & ~sel) | ((d != 0 && c >= d) ? sel : 2'b00);
         reg_status = 4'($urandom);
         reg_rdata  = {32'($urandom), 32'($urandom)};
         if (sel != 2'b00) begin
            reg_status[2*idx+:2] = st;
            reg_rdata[BW*idx+:BW] = rd;
         end
         e_valid   = (c <= k);
         e_pready  = (c == k + 1);
         e_write   = wr;
         e_addr    = addr;
         e_wdata   = data;
         e_mask    = wr ? model_mask(strb) : '1;
         e_pslverr = est[1];
         e_prdata  = (!wr && !est[1]) ? rd : '0;
         @(negedge clk);
         if (o_command_valid) begin last_vcnt++; last_mask = o_write_mask; end
         if (o_pready && last_lat == 0) begin
            last_lat = c; last_prdata = o_prdata; last_pslverr = o_pslverr;
         end
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; reg_sel = '0; reg_ready = '0;
      e_valid = 1'b0; e_pready = 1'b0;
   endtask

   task automatic idle_cycle();
      psel = 1'b0; penable = 1'b0;
      e_valid = 1'b0; e_pready = 1'b0; chk_en = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pstrb = '0; pwdata = '0;
      reg_sel = '0; reg_ready = '0; reg_status = '0; reg_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 64'(o_command_valid), 64'd0);
      chk("reset_pready", 64'(o_pready), 64'd0);
      chk("reset_mask", 64'(o_write_mask), 64'd0);
      chk("reset_prdata", 64'(o_prdata), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Write, strobes 0011, ready on the first BUSY cycle.
      do_xfer(1'b1, 16'h0010, 32'hA5A5_5A5A, 4'b0011, 2'b01, 1, 2'b00, 32'h0, 1'b0);
      chk("lit_wr_mask", 64'(last_mask), 64'h0000_FFFF);
      chk("lit_wr_vcnt", 64'(last_vcnt), 64'd1);
      chk("lit_wr_latency", 64'(last_lat), 64'd2);
      chk("lit_wr_pslverr", 64'(last_pslverr), 64'd0);

      // Read from register 1, ready after 4 BUSY cycles.
      do_xfer(1'b0, 16'h0014, 32'h0, 4'b0000, 2'b10, 4, 2'b00, 32'h1234_5678, 1'b0);
      chk("lit_rd_prdata", 64'(last_prdata), 64'h1234_5678);
      chk("lit_rd_latency", 64'(last_lat), 64'd5);
      chk("lit_rd_pslverr", 64'(last_pslverr), 64'd0);

      // Unmapped address.
      do_xfer(1'b0, 16'h00FC, 32'h0, 4'b0000, 2'b00, 1, 2'b00, 32'hDEAD_BEEF, 1'b0);
      chk("lit_dec_latency", 64'(last_lat), 64'd2);
      chk("lit_dec_pslverr", 64'(last_pslverr), 64'd1);
      chk("lit_dec_prdata", 64'(last_prdata), 64'd0);

      // Slave error on write, then back-to-back okay read.
      do_xfer(1'b1, 16'h0010, 32'h0000_00FF, 4'b1111, 2'b01, 2, 2'b10, 32'h0, 1'b0);
      chk("lit_serr_pslverr", 64'(last_pslverr), 64'd1);
      do_xfer(1'b0, 16'h0010, 32'h0, 4'b0000, 2'b01, 1, 2'b00, 32'hCAFE_F00D, 1'b0);
      chk("lit_b2b_pslverr", 64'(last_pslverr), 64'd0);
      chk("lit_b2b_prdata", 64'(last_prdata), 64'hCAFE_F00D);

`ifdef RGGEN_HOST_IF_TIMEOUT_EN
      do_xfer(1'b0, 16'h0020, 32'h0, 4'b0000, 2'b01, 0, 2'b00, 32'h5555_AAAA, 1'b0);
      chk("lit_to_latency", 64'(last_lat), 64'd9);
      chk("lit_to_pslverr", 64'(last_pslverr), 64'd1);
      chk("lit_to_prdata", 64'(last_prdata), 64'd0);
      do_xfer(1'b0, 16'h0020, 32'h0, 4'b0000, 2'b01, 8, 2'b00, 32'h5555_AAAA, 1'b0);
      chk("lit_to_edge_latency", 64'(last_lat), 64'd9);
      chk("lit_to_edge_pslverr", 64'(last_pslverr), 64'd0);
      chk("lit_to_edge_prdata", 64'(last_prdata), 64'h5555_AAAA);
`else
      do_xfer(1'b0, 16'h0020, 32'h0, 4'b0000, 2'b01, 12, 2'b00, 32'h5555_AAAA, 1'b0);
      chk("lit_long_latency", 64'(last_lat), 64'd13);
      chk("lit_long_prdata", 64'(last_prdata), 64'h5555_AAAA);
`endif

      // Enable high in IDLE without a setup phase must be ignored.
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
      e_valid = 1'b0; e_pready = 1'b0; chk_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle_cycle();

      // Asynchronous reset during BUSY.
      chk_en = 1'b0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030; pstrb = 4'hF;
      reg_sel = 2'b01; reg_ready = 2'b00;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #3;
      chk("prereset_valid", 64'(o_command_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(o_command_valid), 64'd0);
      chk("async_rst_pready", 64'(o_pready), 64'd0);
      chk("async_rst_write", 64'(o_write), 64'd0);
      chk("async_rst_mask", 64'(o_write_mask), 64'd0);
      psel = 1'b0; penable = 1'b0; reg_sel = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_xfer(1'b1, 16'h0030, 32'h0BAD_F00D, 4'b0101, 2'b10, 1, 2'b00, 32'h0, 1'b0);
      chk("lit_post_rst_mask", 64'(last_mask), 64'h00FF_00FF);
      chk("lit_post_rst_latency", 64'(last_lat), 64'd2);

      // Randomised traffic.
      for (int n = 0; n < 80; n++) begin
         logic [1:0] sp;
         logic [1:0] sel;
         int d;
         sp  = 2'($urandom);
         sel = (sp == 2'd0) ? 2'b00 : (sp == 2'd2) ? 2'b10 : 2'b01;
         d   = TO_EN ? $urandom_range(0, 10) : $urandom_range(1, 6);
         do_xfer(1'($urandom), 16'($urandom), 32'($urandom), 4'($urandom), sel, d,
                 2'($urandom), 32'($urandom), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
